// File: rtl/decoder_2x4_pkg.sv
// Purpose : shared widths, types and decode helper for the 2-to-4 line decoder.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package decoder_2x4_pkg;

    localparam int SEL_W = 2;
    localparam int OUT_W = 4;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [OUT_W-1:0] onehot_t;

    localparam onehot_t ONEHOT_IDLE = 4'b0000;

    // Active-high one-hot of a 2-bit code.
    function automatic onehot_t decode_onehot(input sel_t sel);
        onehot_t o;
        o      = ONEHOT_IDLE;
        o[sel] = 1'b1;
        return o;
    endfunction

endpackage

// File: rtl/decoder_2x4_core.sv
// Purpose : combinational 2-to-4 one-hot decode, active-high, gated by en.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; no handshake.
// Ports   : sel[1:0] code in, en decode enable, onehot[3:0] one-hot out (idle when en=0).
module decoder_2x4_core
    import decoder_2x4_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [OUT_W-1:0] onehot
);

    always_comb begin
        onehot = ONEHOT_IDLE;
        if (en) begin
            onehot = decode_onehot(sel);
        end
    end

endmodule

// File: rtl/decoder_2x4.sv
// Purpose : registered 2-to-4 line decoder with enable, valid flag and optional output inversion.
// Latency : 1 cycle; 2 cycles when DECODER_2X4_INPUT_REG_EN is defined (adds an input register).
// Backpressure: none; accepts one code every cycle, never stalls.
// Ports   : clk, rst_n (synchronous, active-low), en, a (select MSB), b (select LSB),
//           y[3:0] one-hot lines indexed by {a,b}, y_valid (registered copy of en).
// Param   : ACTIVE_LOW_OUT=1 inverts y at the output register (idle/reset = 4'b1111).
module decoder_2x4
    import decoder_2x4_pkg::*;
#(
    parameter bit ACTIVE_LOW_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    output logic [OUT_W-1:0] y,
    output logic             y_valid
);

    // XOR mask applied at the output register; all ones flips polarity.
    localparam onehot_t POL_MASK = {OUT_W{ACTIVE_LOW_OUT}};

    sel_t    dec_sel;
    logic    dec_en;
    onehot_t dec_onehot;

`ifdef DECODER_2X4_INPUT_REG_EN
    sel_t sel_q;
    logic en_q;

    // Input stage cleared on reset so in-flight codes are dropped together with the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q <= '0;
            en_q  <= 1'b0;
        end else begin
            sel_q <= {a, b};
            en_q  <= en;
        end
    end

    assign dec_sel = sel_q;
    assign dec_en  = en_q;
`else
    assign dec_sel = {a, b};
    assign dec_en  = en;
`endif

    decoder_2x4_core u_core (
        .sel    (dec_sel),
        .en     (dec_en),
        .onehot (dec_onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y       <= ONEHOT_IDLE ^ POL_MASK;
            y_valid <= 1'b0;
        end else begin
            y       <= dec_onehot ^ POL_MASK;
            y_valid <= dec_en;
        end
    end

endmodule

// File: tb/tb_decoder_2x4.sv
// Purpose : self-checking bench for decoder_2x4, both output polarities side by side.
// Latency : follows DECODER_2X4_INPUT_REG_EN (1 or 2 cycles).
// Backpressure: none.
module tb_decoder_2x4;

`ifdef DECODER_2X4_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       a;
    logic       b;
    logic [3:0] y_hi;
    logic       v_hi;
    logic [3:0] y_lo;
    logic       v_lo;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Per-edge history of what the DUTs sampled.
    bit       h_rst[$];
    bit       h_en[$];
    int       h_idx[$];
    int       n_edges = 0;

    always #5 clk = ~clk;

    decoder_2x4 #(.ACTIVE_LOW_OUT(1'b0)) u_hi (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .y(y_hi), .y_valid(v_hi)
    );

    decoder_2x4 #(.ACTIVE_LOW_OUT(1'b1)) u_lo (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .y(y_lo), .y_valid(v_lo)
    );

    // Expected {valid, active-high y} after edge k: a reset anywhere in the
    // last LAT edges forces idle; otherwise decode the inputs seen LAT-1 edges ago.
    function automatic logic [4:0] model(input int k);
        int s;
        for (int j = k - LAT + 1; j <= k; j++) begin
            if (j < 0 || h_rst[j]) return 5'b0;
        end
        s = k - LAT + 1;
        if (!h_en[s]) return 5'b0;
        return {1'b1, 4'(1 << h_idx[s])};
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s at edge %0d: observed %b expected %b", tag, n_edges, obs, exp);
        end
    endtask

    task automatic check_outputs(input string when);
        logic [4:0] m;
        m = model(n_edges - 1);
        chk({when, "_y_hi"}, y_hi, m[3:0]);
        chk({when, "_v_hi"}, {3'b0, v_hi}, {3'b0, m[4]});
        chk({when, "_y_lo"}, y_lo, ~m[3:0]);
        chk({when, "_v_lo"}, {3'b0, v_lo}, {3'b0, m[4]});
        chk({when, "_onehot"}, {3'b0, ($countones(y_hi) <= 1) && ($countones(~y_lo) <= 1)}, 4'b0001);
    endtask

    // One clock: drive inputs, take the edge, check #1 later. With glitch set,
    // garbage is driven on a/b/en mid-cycle and outputs must not move.
    task automatic step(input bit r, input bit e, input bit ia, input bit ib, input bit glitch);
        if (glitch) begin
            a  = 1'($urandom);
            b  = 1'($urandom);
            en = 1'($urandom);
            #2;
            check_outputs("glitch");
        end
        rst_n = ~r;
        en    = e;
        a     = ia;
        b     = ib;
        @(posedge clk);
        h_rst.push_back(r);
        h_en.push_back(e);
        h_idx.push_back(int'({ia, ib}));
        n_edges++;
        #1;
        check_outputs("edge");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        bit r;
        bit e;
        rst_n = 1'b0;
        en    = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        @(negedge clk);

        // Reset held with en=1, code 11; then release and see 1000 after LAT.
        step(1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 0);
        for (int i = 0; i < LAT + 1; i++) step(0, 1, 1, 1, 0);

        // Exhaustive sweep, one code per cycle, then drain.
        for (int i = 0; i < 4; i++) step(0, 1, i[1], i[0], 0);
        for (int i = 0; i < LAT; i++) step(0, 0, 0, 0, 0);

        // Enable gating: code 10 held, en low then high.
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < LAT + 1; i++) step(0, 1, 1, 0, 0);

        // Polarity case: code 01 (active-low instance should read 1101).
        for (int i = 0; i < LAT + 1; i++) step(0, 1, 0, 1, 0);

        // Mid-stream single-cycle reset while codes toggle every cycle.
        for (int i = 0; i < 10; i++) step(i == 4, 1, i[1], ~i[0], 0);

        // Randomized traffic with occasional resets and mid-cycle glitches.
        for (int i = 0; i < 60; i++) begin
            r = ($urandom_range(0, 9) == 0);
            e = ($urandom_range(0, 3) != 0);
            step(r, e, 1'($urandom), 1'($urandom), 1);
        end
        for (int i = 0; i < LAT; i++) step(0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
